// File: rtl/ual_pkg.sv
// Shared types and constants for the UAL divide unit.
// Holds the divider FSM encoding and width helpers.
package ual_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

   localparam int UAL_WIDTH = 8;
   localparam int UAL_CNT_W = $clog2(UAL_WIDTH + 1);

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/ual_divide_unit_trial_sub.sv
// Trial subtractor for the restoring divider.
// WIDTH+1-bit ripple chain; the result MSB is the borrow.
module div_trial_sub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_shifted,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   logic [WIDTH:0] nb;
   logic [WIDTH:0] sum;

   // Full-adder ripple: rem_shifted + ~divisor + 1
   always_comb begin
      logic c;
      c   = 1'b1;
      nb  = ~{1'b0, divisor};
      sum = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         sum[i] = rem_shifted[i] ^ nb[i] ^ c;
         c      = (rem_shifted[i] & nb[i])
                | (c & (rem_shifted[i] ^ nb[i]));
      end
   end

   // The remainder always fits in WIDTH bits, so bit WIDTH is the borrow
   assign diff   = sum[WIDTH-1:0];
   assign borrow = sum[WIDTH];

endmodule

// File: rtl/ual_divide_unit.sv
// Sequential unsigned restoring divider for the UAL.
// One quotient bit per clock, start/busy/done handshake.
module ual_divide_unit
   import ual_pkg::*;
#(
   parameter int WIDTH = UAL_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] r2,
   input  logic [WIDTH-1:0] r1,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] DU_Q,
   output logic [WIDTH-1:0] DU_R,
   output logic             DZ
);

   localparam int CW = cnt_width(WIDTH);

   div_state_t       state;
   div_state_t       state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;

   logic             accept;
   logic             last;
   logic             dz_op;
   logic             enter_done;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;

   assign accept     = start && (state != RUN);
   assign last       = (count == CW'(WIDTH - 1));
   assign dz_op      = (dvsr == '0);
   assign enter_done = (state == RUN) && (state_nxt == DONE);

   assign rem_sh   = {rem, quo[WIDTH-1]};
   assign step_rem = borrow ? rem_sh[WIDTH-1:0] : diff;
   assign step_quo = {quo[WIDTH-2:0], ~borrow};

   div_trial_sub #(
      .WIDTH (WIDTH)
   ) u_trial (
      .rem_shifted (rem_sh),
      .divisor     (dvsr),
      .diff        (diff),
      .borrow      (borrow)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state; a zero divisor spends one RUN cycle before DONE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (dz_op || last) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Operand capture and shift-subtract iteration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         rem   <= '0;
         quo   <= '0;
         dvsr  <= '0;
      end else if (accept) begin
         count <= '0;
         rem   <= '0;
         quo   <= r2;
         dvsr  <= r1;
      end else if (state == RUN && !dz_op) begin
         count <= count + CW'(1);
         rem   <= step_rem;
         quo   <= step_quo;
      end
   end

   // Results load only on entry to DONE and hold until the next one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         DU_Q <= '0;
         DU_R <= '0;
         DZ   <= 1'b0;
      end else if (enter_done) begin
         if (dz_op) begin
            DU_Q <= '1;
            DU_R <= quo;
            DZ   <= 1'b1;
         end else begin
            DU_Q <= step_quo;
            DU_R <= step_rem;
            DZ   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ual_divide_unit.sv
// Self-checking bench for ual_divide_unit.
// Directed steps plus a random sweep against a / and % model.
module tb_ual_divide_unit;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] r2;
   logic [7:0] r1;
   logic       busy;
   logic       done;
   logic [7:0] DU_Q;
   logic [7:0] DU_R;
   logic       DZ;

   int errors = 0;
   int checks = 0;

   ual_divide_unit #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .r2    (r2),
      .r1    (r1),
      .busy  (busy),
      .done  (done),
      .DU_Q  (DU_Q),
      .DU_R  (DU_R),
      .DZ    (DZ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: unsigned quotient/remainder, all-ones/dividend on zero
   task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic z);
      if (b == 0) begin
         q = 8'hFF; r = a; z = 1'b1;
      end else begin
         q = 8'(a / b); r = 8'(a % b); z = 1'b0;
      end
   endtask

   // Launch one op; lat = edge index (from accept edge E) sampling done
   task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                         output int lat);
      int n;
      r2 = a; r1 = b; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      lat = n + 1;
      chk("done_seen", 32'(done), 32'd1);
   endtask

   task automatic op_check(input string tag, input logic [7:0] a,
                           input logic [7:0] b);
      int lat;
      logic [7:0] q, r;
      logic z;
      ref_div(a, b, q, r, z);
      do_div(a, b, lat);
      chk({tag, "_lat"}, 32'(lat), (b == 0) ? 32'd2 : 32'd9);
      chk({tag, "_q"}, 32'(DU_Q), 32'(q));
      chk({tag, "_r"}, 32'(DU_R), 32'(r));
      chk({tag, "_dz"}, 32'(DZ), 32'(z));
      tick();
   endtask

   initial begin
      int pulses;
      int lat_seen;
      logic [7:0] q_seen, r_seen;
      logic [7:0] a, b;

      rst = 1'b1; start = 1'b0; r2 = '0; r1 = '0;
      tick(); tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", 32'(DU_Q), 32'd0);
      chk("rst_r", 32'(DU_R), 32'd0);
      chk("rst_dz", 32'(DZ), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // 200/7 with per-cycle handshake timing
      r2 = 8'd200; r1 = 8'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 8; n++) begin
         chk("t1_busy", 32'(busy), 32'd1);
         chk("t1_nodone", 32'(done), 32'd0);
         tick();
      end
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_busy_lo", 32'(busy), 32'd0);
      chk("t1_q", 32'(DU_Q), 32'd28);
      chk("t1_r", 32'(DU_R), 32'd4);
      chk("t1_dz", 32'(DZ), 32'd0);
      tick();
      chk("t1_pulse", 32'(done), 32'd0);

      op_check("t2a", 8'd5, 8'd9);
      op_check("t2b", 8'd255, 8'd1);
      op_check("t2c", 8'd255, 8'd255);

      op_check("t3_dz", 8'd100, 8'd0);
      op_check("t3_after", 8'd9, 8'd3);

      // start while busy is ignored
      r2 = 8'd200; r1 = 8'd7; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; r2 = 8'd50; r1 = 8'd5;
      tick();
      start = 1'b0; r1 = 8'd1;
      pulses = 0; lat_seen = 0; q_seen = '0; r_seen = '0;
      for (int n = 3; n < 16; n++) begin
         if (done) begin
            pulses++;
            lat_seen = n + 1;
            q_seen = DU_Q;
            r_seen = DU_R;
         end
         tick();
      end
      chk("t4_pulses", 32'(pulses), 32'd1);
      chk("t4_lat", 32'(lat_seen), 32'd9);
      chk("t4_q", 32'(q_seen), 32'd28);
      chk("t4_r", 32'(r_seen), 32'd4);

      // async reset mid-operation
      r2 = 8'd200; r1 = 8'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_q", 32'(DU_Q), 32'd0);
      chk("t5_r", 32'(DU_R), 32'd0);
      chk("t5_dz", 32'(DZ), 32'd0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < 12; n++) begin
         if (done) pulses++;
         tick();
      end
      chk("t5_nodone", 32'(pulses), 32'd0);
      op_check("t5_after", 8'd81, 8'd9);

      // back-to-back: start held through DONE
      r2 = 8'd200; r1 = 8'd7; start = 1'b1;
      tick();
      r2 = 8'd17; r1 = 8'd4;
      repeat (8) tick();
      chk("t6_done1", 32'(done), 32'd1);
      chk("t6_q1", 32'(DU_Q), 32'd28);
      chk("t6_r1", 32'(DU_R), 32'd4);
      tick();
      start = 1'b0;
      chk("t6_nogap", 32'(busy), 32'd1);
      repeat (8) tick();
      chk("t6_done2", 32'(done), 32'd1);
      chk("t6_q2", 32'(DU_Q), 32'd4);
      chk("t6_r2", 32'(DU_R), 32'd1);
      tick();

      // random sweep, nonzero divisors
      for (int i = 0; i < 40; i++) begin
         int lat;
         a = 8'($urandom_range(255));
         b = 8'($urandom_range(255, 1));
         do_div(a, b, lat);
         chk("rnd_lat", 32'(lat), 32'd9);
         chk("rnd_q", 32'(DU_Q), 32'(a / b));
         chk("rnd_r", 32'(DU_R), 32'(a % b));
         chk("rnd_inv", 32'(DU_Q) * 32'(b) + 32'(DU_R), 32'(a));
         chk("rnd_rlt", 32'(DU_R < b), 32'd1);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
